// File: rtl/room_temp_model.sv
// rtl/room_temp_model.sv - behavioural room thermal plant driven by heat/cool commands
// Temperature ramps at STEP_CYCLES per degree, drifts to AMBIENT at DRIFT_CYCLES per degree.
module room_temp_model #(
  parameter logic [4:0] INIT_TEMP    = 5'd20,
  parameter logic [4:0] AMBIENT      = 5'd15,
  parameter int         STEP_CYCLES  = 8,
  parameter int         DRIFT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heat,
  input  logic       cool,
  input  logic       load_en,
  input  logic [4:0] load_val,
  output logic [4:0] temp,
  output logic [1:0] mode,
  output logic       fault,
  output logic       at_limit
);

  typedef enum logic [1:0] {
    MODE_DRIFT = 2'd0,
    MODE_HEAT  = 2'd1,
    MODE_COOL  = 2'd2,
    MODE_FAULT = 2'd3
  } mode_e;

  localparam logic [7:0] STEP_M1  = 8'(STEP_CYCLES - 1);
  localparam logic [7:0] DRIFT_M1 = 8'(DRIFT_CYCLES - 1);
  localparam logic [4:0] TEMP_MAX = 5'd31;
  localparam logic [4:0] TEMP_MIN = 5'd0;

  mode_e      r_mode;
  mode_e      w_next_mode;
  logic [4:0] r_temp;
  logic [4:0] w_temp_nxt;
  logic [4:0] w_step_temp;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_rate_m1;
  logic       r_fault;
  logic       r_at_limit;

  always_comb begin
    w_next_mode = MODE_DRIFT;
    case ({heat, cool})
      2'b10:   w_next_mode = MODE_HEAT;
      2'b01:   w_next_mode = MODE_COOL;
      2'b11:   w_next_mode = MODE_FAULT;
      default: w_next_mode = MODE_DRIFT;
    endcase
  end

  // Candidate temperature if the rate counter expires this edge; saturates, never wraps.
  always_comb begin
    w_step_temp = r_temp;
    w_rate_m1   = (r_mode == MODE_DRIFT) ? DRIFT_M1 : STEP_M1;
    case (r_mode)
      MODE_HEAT: if (r_temp != TEMP_MAX) w_step_temp = r_temp + 5'd1;
      MODE_COOL: if (r_temp != TEMP_MIN) w_step_temp = r_temp - 5'd1;
      MODE_DRIFT: begin
        if (r_temp > AMBIENT)      w_step_temp = r_temp - 5'd1;
        else if (r_temp < AMBIENT) w_step_temp = r_temp + 5'd1;
      end
      default: w_step_temp = r_temp;
    endcase
  end

  always_comb begin
    w_temp_nxt = r_temp;
    w_cnt_nxt  = r_cnt;
    if (load_en) begin
      w_temp_nxt = load_val;
      w_cnt_nxt  = 8'd0;
    end else if (w_next_mode != r_mode || r_mode == MODE_FAULT) begin
      w_cnt_nxt  = 8'd0;
    end else if (r_cnt == w_rate_m1) begin
      w_cnt_nxt  = 8'd0;
      w_temp_nxt = w_step_temp;
    end else begin
      w_cnt_nxt  = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= MODE_DRIFT;
      r_temp     <= INIT_TEMP;
      r_cnt      <= 8'd0;
      r_fault    <= 1'b0;
      r_at_limit <= (INIT_TEMP == TEMP_MIN) || (INIT_TEMP == TEMP_MAX);
    end else begin
      r_mode     <= w_next_mode;
      r_temp     <= w_temp_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fault    <= (w_next_mode == MODE_FAULT);
      r_at_limit <= (w_temp_nxt == TEMP_MIN) || (w_temp_nxt == TEMP_MAX);
    end
  end

  assign temp     = r_temp;
  assign mode     = r_mode;
  assign fault    = r_fault;
  assign at_limit = r_at_limit;

endmodule

// File: tb/tb_room_temp_model.sv
// tb/tb_room_temp_model.sv - scoreboard bench for room_temp_model
// Expected outputs come from an elapsed-edge model of the plant rules.
module tb_room_temp_model;

  localparam int INIT  = 20;
  localparam int AMB   = 15;
  localparam int STEP  = 8;
  localparam int DRIFT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       heat, cool, load_en;
  logic [4:0] load_val;
  logic [4:0] temp;
  logic [1:0] mode;
  logic       fault, at_limit;

  typedef struct {
    int t;
    int m;
    int f;
    int a;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: mode, temperature, and edges spent in the current mode since last restart.
  int m_mode, m_temp, m_elapsed;

  room_temp_model #(
    .INIT_TEMP(5'd20), .AMBIENT(5'd15), .STEP_CYCLES(8), .DRIFT_CYCLES(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .heat(heat), .cool(cool),
    .load_en(load_en), .load_val(load_val),
    .temp(temp), .mode(mode), .fault(fault), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_temp = INIT; m_elapsed = 0;
  endtask

  task automatic model_edge(input int h, input int c, input int le, input int lv, output exp_t e);
    int nm;
    nm = (h && c) ? 3 : h ? 1 : c ? 2 : 0;
    if (!rst_n) begin
      model_reset();
      e.f = 0;
    end else begin
      if (le) begin
        m_temp = lv; m_elapsed = 0; m_mode = nm;
      end else if (nm != m_mode) begin
        m_mode = nm; m_elapsed = 0;
      end else if (m_mode != 3) begin
        m_elapsed++;
        if (m_elapsed % ((m_mode == 0) ? DRIFT : STEP) == 0) begin
          if (m_mode == 1)      m_temp = (m_temp < 31) ? m_temp + 1 : 31;
          else if (m_mode == 2) m_temp = (m_temp > 0) ? m_temp - 1 : 0;
          else if (m_temp > AMB) m_temp--;
          else if (m_temp < AMB) m_temp++;
        end
      end
      e.f = (nm == 3) ? 1 : 0;
    end
    e.t = m_temp;
    e.m = m_mode;
    e.a = (m_temp == 0 || m_temp == 31) ? 1 : 0;
  endtask

  task automatic drive(input int h, input int c, input int le, input int lv, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      heat = h[0]; cool = c[0]; load_en = le[0]; load_val = lv[4:0];
      model_edge(h, c, le, lv, e);
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("temp", int'(temp), e.t);
      check("mode", int'(mode), e.m);
      check("fault", int'(fault), e.f);
      check("at_limit", int'(at_limit), e.a);
    end
  end

  initial begin
    rst_n = 1'b0; heat = 1'b0; cool = 1'b0; load_en = 1'b0; load_val = 5'd0;
    model_reset();
    #7;
    check("reset_temp", int'(temp), 20);
    check("reset_mode", int'(mode), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_at_limit", int'(at_limit), 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 0, 0, 0, 30);
    drive(1, 0, 1, 29, 1);  drive(1, 0, 0, 0, 120);
    drive(0, 1, 1, 2, 1);   drive(0, 1, 0, 0, 30);  drive(1, 0, 0, 0, 10);
    drive(1, 0, 1, 23, 1);  drive(1, 0, 0, 0, 12);
    drive(1, 1, 0, 0, 50);  drive(1, 0, 0, 0, 10);
    drive(0, 0, 1, 18, 1);  drive(0, 0, 0, 0, 120);
    drive(0, 0, 1, 12, 1);  drive(0, 0, 0, 0, 120);
    drive(1, 0, 1, 26, 1);  drive(1, 0, 0, 0, 11);

    // Asynchronous reset between edges during a heat ramp.
    @(posedge clk);
    #3;
    check("pre_reset_temp", int'(temp), 27);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_temp", int'(temp), 20);
    check("async_mode", int'(mode), 0);
    check("async_fault", int'(fault), 0);
    check("async_at_limit", int'(at_limit), 0);
    drive(1, 0, 0, 0, 2);
    @(negedge clk);
    rst_n = 1'b1;
    heat = 1'b0; cool = 1'b0;
    drive(1, 0, 0, 0, 20);

    for (int seg = 0; seg < 60; seg++) begin
      int h, c, le, lv, len;
      h   = ($urandom_range(0, 2) != 0) ? 1 : 0;
      c   = ($urandom_range(0, 2) == 0) ? 1 : 0;
      le  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      lv  = $urandom_range(0, 31);
      len = $urandom_range(1, 40);
      if (le) drive(h, c, 1, lv, 1);
      drive(h, c, 0, 0, len);
    end

    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
